pipelined_sigmoid: RTL and testbench
====================================

PIPELINED_SIGMOID -- requirements
Module: pipelined_sigmoid

Interface
REQ-001 The block SHALL have parameter IW, default 8, meaning integer bits of input/output, sign included.
REQ-002 The block SHALL have parameter FW, default 8, meaning fraction bits, FW>=2; W = IW+FW.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  sample offered.
REQ-006 The block SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-007 The block SHALL have port in_data  input  W  signed two's complement, Q(IW).(FW).
REQ-008 The block SHALL have port in_mode  input  1  0 = sigmoid, 1 = tanh, captured with the sample.
REQ-009 The block SHALL have port out_valid  output  1  result present.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-011 The block SHALL have port out_data  output  W  signed Q(IW).(FW) result.
REQ-012 The block SHALL have port out_sat  output  1  input magnitude was clamped for this result.
REQ-013 The block SHALL have port out_count  output  16  number of completed output handshakes, wrapping.

Function
REQ-014 Constants: ONE = 1<<FW, HALF = 1<<(FW-1).
REQ-015 Stage 1 registers v: v = in_data in sigmoid mode; in tanh mode v = 2*in_data, saturated to [min, max] of W bits.
REQ-016 Stage 1 registers neg = v[W-1] and a = |v|; a = 2^(W-1)-1 when v is the most negative value.
REQ-017 out_sat SHALL be 1 when stage 1 saturated the doubling or clamped the absolute value, and 0 otherwise.
REQ-018 Stage 2: n = a[W-1:FW], f = a[FW-1:0], g = HALF - (f>>2), h = (n > FW) ? 0 : g >> n; h is registered.
REQ-019 Stage 3: s = neg ? h : ONE - h; out_data = s in sigmoid mode, and 2*s - ONE in tanh mode.
REQ-020 Mode, neg and sat flags SHALL travel with their sample through every stage.
REQ-021 Pipeline SHALL be exactly 3 register stages; latency is 3 cycles from accept to out_valid with out_ready held high.
REQ-022 Throughput SHALL be 1 sample per cycle with out_ready high.
REQ-023 Global advance = !out_valid || out_ready; in_ready = advance; all stages shift only when advance is 1.
REQ-024 Empty stages (bubbles) SHALL carry valid = 0 and shift normally.
REQ-025 While out_valid && !out_ready, out_data, out_sat and all stage contents SHALL hold stable.
REQ-026 out_count SHALL increment on each out_valid && out_ready and wrap from 0xFFFF to 0x0000.
REQ-027 in_ready SHALL depend combinationally only on out_valid and out_ready, with no path from in_valid.

Reset
REQ-028 With rst high at a clock edge, all stage valids, out_valid, out_sat, out_data and out_count SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all in-flight samples, with no partial output.
REQ-030 in_ready SHALL be 1 in the cycle after reset.

Structure
REQ-031 Package sigmoid_pkg SHALL hold the mode typedef (MODE_SIGMOID = 0, MODE_TANH = 1), PIPE_DEPTH = 3 and COUNT_W = 16.
REQ-032 Stage-2 arithmetic SHALL live in one combinational sub-module, pwl_shift_unit, parametrised by IW and FW (inputs a; output h).
REQ-033 The top SHALL hold pipeline registers, handshake and counter only.

Verification
REQ-034 Sigmoid points, defaults: in_data 0x0000 -> 0x0080; 0x0100 -> 0x00C0; 0xFF00 -> 0x0040; 0x0080 -> 0x00A0; out_sat = 0 for all.
REQ-035 Saturation: sigmoid 0x8000 -> 0x0000 with out_sat = 1; tanh 0x7F00 -> 0x0100 with out_sat = 1; tanh 0x0080 -> 0x0080 with out_sat = 0.
REQ-036 Streaming: 10 back-to-back samples with out_ready = 1 -> first out_valid exactly 3 cycles after first accept, then 10 consecutive results in order, and out_count = 10.
REQ-037 Backpressure: 3 samples accepted, then out_ready = 0 for 5 cycles -> in_ready = 0 and out_data stable throughout; after release the 3 results emerge in order with none lost or duplicated.
REQ-038 Mixed modes: alternating in_mode 0/1 on in_data 0x0080 -> outputs alternate 0x00A0/0x0080.
REQ-039 Reset mid-stream (2 samples in flight, out_count = 5) -> next cycle out_valid = 0, out_count = 0, in_ready = 1, and no stale result appears afterwards.

Source files
------------

// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the pipelined sigmoid/tanh approximator.
package sigmoid_pkg;

   typedef enum logic {
      MODE_SIGMOID = 1'b0,
      MODE_TANH    = 1'b1
   } mode_e;

   localparam int unsigned PIPE_DEPTH = 3;
   localparam int unsigned COUNT_W    = 16;

   // Side-band flags that travel with each sample through the pipeline.
   typedef struct packed {
      logic  valid;
      mode_e mode;
      logic  neg;
      logic  sat;
   } ctl_t;

endpackage

// File: rtl/pipelined_sigmoid_pwl_shift_unit.sv
// Piecewise-linear shift approximation of the sigmoid tail for a magnitude a.
module pwl_shift_unit #(
   parameter int unsigned IW = 8,
   parameter int unsigned FW = 8
) (
   input  logic [IW+FW-1:0] a,
   output logic [FW-1:0]    h
);

   localparam int unsigned W = IW + FW;
   localparam logic [FW-1:0] HALF = FW'(1) << (FW - 1);

   logic [IW-1:0] n;
   logic [FW-1:0] f;
   logic [FW-1:0] g;

   assign n = a[W-1:FW];
   assign f = a[FW-1:0];
   // f>>2 stays below HALF, so g never underflows.
   assign g = HALF - (f >> 2);
   assign h = (32'(n) > FW) ? '0 : (g >> n);

endmodule

// File: rtl/pipelined_sigmoid.sv
// Three-stage sigmoid/tanh pipeline with a single global advance and output counter.
module pipelined_sigmoid
   import sigmoid_pkg::*;
#(
   parameter int unsigned IW = 8,
   parameter int unsigned FW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IW+FW-1:0]    in_data,
   input  logic                in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IW+FW-1:0]    out_data,
   output logic                out_sat,
   output logic [COUNT_W-1:0]  out_count
);

   localparam int unsigned W = IW + FW;
   localparam logic [W-1:0] ONE   = W'(1) << FW;
   localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

   logic          advance;
   ctl_t          ctl1, ctl2;
   logic [W-1:0]  a1;
   logic [FW-1:0] h2;

   logic [W-1:0]  v_c, a_c, s_c, res_c;
   logic          dbl_sat_c, abs_sat_c;
   logic [FW-1:0] h_c;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage 1: optional saturating doubling, then clamped magnitude.
   always_comb begin
      v_c       = in_data;
      dbl_sat_c = 1'b0;
      if (mode_e'(in_mode) == MODE_TANH) begin
         if (in_data[W-1] != in_data[W-2]) begin
            dbl_sat_c = 1'b1;
            v_c       = in_data[W-1] ? S_MIN : S_MAX;
         end else begin
            v_c = {in_data[W-2:0], 1'b0};
         end
      end
      abs_sat_c = (v_c == S_MIN);
      if (abs_sat_c)
         a_c = S_MAX;
      else if (v_c[W-1])
         a_c = W'(-v_c);
      else
         a_c = v_c;
   end

   pwl_shift_unit #(.IW(IW), .FW(FW)) u_pwl (
      .a (a1),
      .h (h_c)
   );

   // Stage 3: mirror for negative inputs, rescale for tanh.
   always_comb begin
      s_c   = ctl2.neg ? W'(h2) : (ONE - W'(h2));
      res_c = s_c;
      if (ctl2.mode == MODE_TANH)
         res_c = (s_c << 1) - ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctl1      <= '0;
         ctl2      <= '0;
         a1        <= '0;
         h2        <= '0;
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else begin
         if (out_valid && out_ready)
            out_count <= out_count + COUNT_W'(1);
         if (advance) begin
            ctl1.valid <= in_valid;
            ctl1.mode  <= mode_e'(in_mode);
            ctl1.neg   <= v_c[W-1];
            ctl1.sat   <= dbl_sat_c | abs_sat_c;
            a1         <= a_c;
            ctl2       <= ctl1;
            h2         <= h_c;
            out_valid  <= ctl2.valid;
            out_sat    <= ctl2.sat;
            out_data   <= res_c;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_sigmoid.sv
// Self-checking bench for pipelined_sigmoid: vector table, streaming, backpressure, reset.
module tb_pipelined_sigmoid;

   localparam int unsigned IW = 8;
   localparam int unsigned FW = 8;
   localparam int unsigned W  = IW + FW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_mode;
   logic          out_valid, out_ready, out_sat;
   logic [W-1:0]  in_data, out_data;
   logic [15:0]   out_count;

   always #5 clk = ~clk;

   pipelined_sigmoid #(.IW(IW), .FW(FW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_count (out_count)
   );

   typedef struct packed {
      logic [W-1:0] data;
      logic         sat;
   } exp_t;

   typedef struct {
      logic [W-1:0] din;
      logic         mode;
      logic [W-1:0] data;
      logic         sat;
   } vec_t;

   exp_t sb[$];
   exp_t drv_exp;
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Independent integer model of the approximation.
   function automatic exp_t model(logic [W-1:0] d, logic m);
      int   x, a, n, f, g, h, s, r;
      logic sat;
      exp_t e;
      x   = int'($signed(d));
      sat = 1'b0;
      if (m) begin
         x = 2 * x;
         if (x > 32767) begin x = 32767; sat = 1'b1; end
         else if (x < -32768) begin x = -32768; sat = 1'b1; end
      end
      if (x == -32768) begin a = 32767; sat = 1'b1; end
      else a = (x < 0) ? -x : x;
      n = a / 256;
      f = a % 256;
      g = 128 - f / 4;
      h = (n > 8) ? 0 : (g >> n);
      s = (x < 0) ? h : 256 - h;
      r = m ? 2 * s - 256 : s;
      e.data = W'(r);
      e.sat  = sat;
      return e;
   endfunction

   // One clock: score handshakes seen before the edge, then advance.
   task automatic cycle();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h with nothing expected", out_data);
         end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_sat", 32'(out_sat), 32'(e.sat));
            pops++;
         end
      end
      if (in_valid && in_ready)
         sb.push_back(drv_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [W-1:0] d, logic m, exp_t e);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      drv_exp  = e;
   endtask

   task automatic drain(int max_cycles);
      in_valid = 1'b0;
      for (int k = 0; k < max_cycles && sb.size() != 0; k++)
         cycle();
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      exp_t e;
      exp_t exp_a0, exp_80;
      logic [W-1:0] held;
      int first_v, last_v, ones, p0, vcnt;

      vecs[0] = '{16'h0000, 1'b0, 16'h0080, 1'b0};
      vecs[1] = '{16'h0100, 1'b0, 16'h00C0, 1'b0};
      vecs[2] = '{16'hFF00, 1'b0, 16'h0040, 1'b0};
      vecs[3] = '{16'h0080, 1'b0, 16'h00A0, 1'b0};
      vecs[4] = '{16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{16'h7F00, 1'b1, 16'h0100, 1'b1};
      vecs[6] = '{16'h0080, 1'b1, 16'h0080, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
      out_ready = 1'b1; drv_exp = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Reference points, one at a time.
      for (int i = 0; i < 7; i++) begin
         e.data = vecs[i].data;
         e.sat  = vecs[i].sat;
         drive(vecs[i].din, vecs[i].mode, e);
         cycle();
         drain(10);
      end
      check("table_pops", 32'(pops), 32'd7);

      // Streaming: latency, contiguous results and count.
      do_reset();
      first_v = -1; last_v = -1; ones = 0;
      for (int k = 1; k <= 14; k++) begin
         if (k <= 10) begin
            in_data = W'($urandom_range(0, 65535));
            in_mode = 1'($urandom_range(0, 1));
            drive(in_data, in_mode, model(in_data, in_mode));
         end else begin
            in_valid = 1'b0;
         end
         cycle();
         if (out_valid) begin
            if (first_v < 0) first_v = k;
            last_v = k;
            ones++;
         end
      end
      check("stream_latency", 32'(first_v), 32'd3);
      check("stream_len", 32'(ones), 32'd10);
      check("stream_contig", 32'(last_v - first_v + 1), 32'd10);
      check("stream_count", 32'(out_count), 32'd10);
      check("stream_empty", 32'(sb.size()), 32'd0);

      // Backpressure: stall with a full pipeline and an offered sample.
      do_reset();
      p0 = pops;
      for (int k = 0; k < 3; k++) begin
         in_data = W'(16'h0040 * (k + 1));
         drive(in_data, 1'(k), model(in_data, 1'(k)));
         cycle();
      end
      check("bp_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      held      = out_data;
      drive(16'hFE80, 1'b0, model(16'hFE80, 1'b0));
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_data", 32'(out_data), 32'(held));
      end
      out_ready = 1'b1;
      cycle();
      drain(12);
      check("bp_results", 32'(pops - p0), 32'd4);
      check("bp_count", 32'(out_count), 32'd4);

      // Alternating modes on the same input.
      do_reset();
      exp_a0.data = 16'h00A0; exp_a0.sat = 1'b0;
      exp_80.data = 16'h0080; exp_80.sat = 1'b0;
      p0 = pops;
      for (int k = 0; k < 6; k++) begin
         drive(16'h0080, 1'(k & 1), (k & 1) ? exp_80 : exp_a0);
         cycle();
      end
      drain(10);
      check("mixed_results", 32'(pops - p0), 32'd6);

      // Reset with samples in flight.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         in_data = W'(16'h0100 * k);
         drive(in_data, 1'b0, model(in_data, 1'b0));
         cycle();
      end
      drain(10);
      check("pre_rst_count", 32'(out_count), 32'd5);
      for (int k = 0; k < 2; k++) begin
         drive(16'h0300, 1'b1, model(16'h0300, 1'b1));
         cycle();
      end
      do_reset();
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(out_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      vcnt = 0;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (out_valid) vcnt++;
      end
      check("mid_rst_no_stale", 32'(vcnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
